// File: rtl/adpcm_voice_scheduler_if.sv
// Bus bundle for adpcm_voice_scheduler: command port, sample-ROM port, decode datapath and mix output.
// Defining ADPCM_SCHED_VOLUME_EN adds the per-voice volume field io_cmd_vol to the command port.
interface adpcm_voice_scheduler_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  io_cmd_valid;
  logic                  io_cmd_ready;
  logic [2:0]            io_cmd_voice;
  logic                  io_cmd_stop;
  logic [ADDR_WIDTH-1:0] io_cmd_start;
  logic [ADDR_WIDTH-1:0] io_cmd_end;
`ifdef ADPCM_SCHED_VOLUME_EN
  logic [3:0]            io_cmd_vol;
`endif
  logic                  io_tick;
  logic                  io_rom_rd;
  logic [ADDR_WIDTH-1:0] io_rom_addr;
  logic [7:0]            io_rom_data;
  logic                  io_rom_valid;
  logic [3:0]            io_dec_data;
  logic [16:0]           io_dec_in_step;
  logic [16:0]           io_dec_in_sample;
  logic [16:0]           io_dec_out_step;
  logic [16:0]           io_dec_out_sample;
  logic [15:0]           io_audio;
  logic                  io_audio_valid;
  logic                  io_busy;
  logic                  io_overrun;

  // Scheduler side.
  modport slave (
`ifdef ADPCM_SCHED_VOLUME_EN
    input  io_cmd_vol,
`endif
    input  io_cmd_valid, io_cmd_voice, io_cmd_stop, io_cmd_start, io_cmd_end,
    input  io_tick, io_rom_data, io_rom_valid, io_dec_out_step, io_dec_out_sample,
    output io_cmd_ready, io_rom_rd, io_rom_addr, io_dec_data, io_dec_in_step,
    output io_dec_in_sample, io_audio, io_audio_valid, io_busy, io_overrun
  );

  // Environment side: CPU command file, ROM arbiter, decode datapath, mixer.
  modport master (
`ifdef ADPCM_SCHED_VOLUME_EN
    output io_cmd_vol,
`endif
    output io_cmd_valid, io_cmd_voice, io_cmd_stop, io_cmd_start, io_cmd_end,
    output io_tick, io_rom_data, io_rom_valid, io_dec_out_step, io_dec_out_sample,
    input  io_cmd_ready, io_rom_rd, io_rom_addr, io_dec_data, io_dec_in_step,
    input  io_dec_in_sample, io_audio, io_audio_valid, io_busy, io_overrun
  );
endinterface

// File: rtl/adpcm_voice_scheduler.sv
// Shares one ADPCM decode datapath across VOICES channels per sample tick, then emits a saturated mix.
// Optional ADPCM_SCHED_VOLUME_EN: per-voice arithmetic-shift volume latched on start.
module adpcm_voice_scheduler #(
  parameter int VOICES     = 4,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                    clock,
  input  logic                    reset,
  adpcm_voice_scheduler_if.slave  bus
);
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, FETCH, DECODE, NEXT, MIX} state_t;

  state_t                 state, state_nxt;
  logic [VW-1:0]          v;
  logic [VOICES-1:0]      active;
  logic [VOICES-1:0]      phase;
  logic [VOICES-1:0]      pass_mask;
  logic [ADDR_WIDTH-1:0]  addr     [VOICES];
  logic [ADDR_WIDTH-1:0]  end_addr [VOICES];
  logic [7:0]             byte_buf [VOICES];
  logic [16:0]            step     [VOICES];
  logic signed [16:0]     sample   [VOICES];
`ifdef ADPCM_SCHED_VOLUME_EN
  logic [3:0]             vol      [VOICES];
`endif
  logic                   cmd_fire, cmd_hit;
  logic [VW-1:0]          cmd_idx;
  logic signed [19:0]     mix_sum;
  logic [15:0]            mix_sat;

  assign cmd_fire = bus.io_cmd_valid && (state == IDLE);
  assign cmd_hit  = (int'(bus.io_cmd_voice) < VOICES);
  assign cmd_idx  = bus.io_cmd_voice[VW-1:0];

  assign bus.io_cmd_ready = (state == IDLE);
  assign bus.io_busy      = (state != IDLE);
  assign bus.io_rom_rd    = (state == FETCH);
  assign bus.io_rom_addr  = (state == FETCH) ? addr[v] : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.io_tick) state_nxt = SCAN;
      SCAN:    if (!active[v]) state_nxt = NEXT;
               else if (!phase[v]) state_nxt = FETCH;
               else state_nxt = DECODE;
      FETCH:   if (bus.io_rom_valid) state_nxt = DECODE;
      DECODE:  state_nxt = NEXT;
      NEXT:    state_nxt = (v == VW'(VOICES - 1)) ? MIX : SCAN;
      MIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.io_dec_data      = '0;
    bus.io_dec_in_step   = '0;
    bus.io_dec_in_sample = '0;
    if (state == DECODE) begin
      bus.io_dec_data      = phase[v] ? byte_buf[v][3:0] : byte_buf[v][7:4];
      bus.io_dec_in_step   = step[v];
      bus.io_dec_in_sample = sample[v];
    end
  end

  // Only voices active when the pass began are mixed, so a voice finishing mid-pass still counts once.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (pass_mask[i]) begin
`ifdef ADPCM_SCHED_VOLUME_EN
        mix_sum = mix_sum + 20'(sample[i] >>> vol[i]);
`else
        mix_sum = mix_sum + 20'(sample[i]);
`endif
      end
    end
    if (mix_sum > 20'sd32767)       mix_sat = 16'h7fff;
    else if (mix_sum < -20'sd32768) mix_sat = 16'h8000;
    else                            mix_sat = mix_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      v                  <= '0;
      pass_mask          <= '0;
      bus.io_audio       <= '0;
      bus.io_audio_valid <= 1'b0;
      bus.io_overrun     <= 1'b0;
    end else begin
      state              <= state_nxt;
      bus.io_audio_valid <= 1'b0;
      if (state != IDLE && bus.io_tick) bus.io_overrun <= 1'b1;
      // Voice 0 cannot change before its own SCAN, so this snapshot equals the pass-start state.
      if (state == SCAN && v == '0) pass_mask <= active;
      if (state == IDLE) v <= '0;
      if (state == NEXT) v <= (v == VW'(VOICES - 1)) ? '0 : v + VW'(1);
      if (state == MIX) begin
        bus.io_audio       <= mix_sat;
        bus.io_audio_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= '0;
      phase  <= '0;
      for (int i = 0; i < VOICES; i++) begin
        addr[i]     <= '0;
        end_addr[i] <= '0;
        byte_buf[i] <= '0;
        step[i]     <= 17'd127;
        sample[i]   <= '0;
`ifdef ADPCM_SCHED_VOLUME_EN
        vol[i]      <= '0;
`endif
      end
    end else begin
      if (cmd_fire && cmd_hit) begin
        if (bus.io_cmd_stop) begin
          active[cmd_idx] <= 1'b0;
          sample[cmd_idx] <= '0;
        end else begin
          active[cmd_idx]   <= 1'b1;
          addr[cmd_idx]     <= bus.io_cmd_start;
          end_addr[cmd_idx] <= bus.io_cmd_end;
          phase[cmd_idx]    <= 1'b0;
          step[cmd_idx]     <= 17'd127;
          sample[cmd_idx]   <= '0;
`ifdef ADPCM_SCHED_VOLUME_EN
          vol[cmd_idx]      <= bus.io_cmd_vol;
`endif
        end
      end
      if (state == FETCH && bus.io_rom_valid) byte_buf[v] <= bus.io_rom_data;
      if (state == DECODE) begin
        step[v]   <= bus.io_dec_out_step;
        sample[v] <= bus.io_dec_out_sample;
        phase[v]  <= ~phase[v];
        if (phase[v]) begin
          addr[v] <= addr[v] + ADDR_WIDTH'(1);
          if (addr[v] == end_addr[v]) active[v] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_adpcm_voice_scheduler.sv
// Self-checking bench for adpcm_voice_scheduler: behavioural per-pass model, ROM responder and decode datapath.
`timescale 1ns/1ps
module tb_adpcm_voice_scheduler;
  localparam int VOICES = 4;
  localparam int AW     = 18;

  typedef struct packed {
    logic [3:0]  code;
    logic [16:0] step;
    logic [16:0] sample;
  } dec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  adpcm_voice_scheduler_if #(.ADDR_WIDTH(AW)) bus();
  adpcm_voice_scheduler #(.VOICES(VOICES), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int rom_lat = 2;
  logic [7:0] rom [1024];
  int   act_reads[$], exp_reads[$];
  dec_t act_dec[$], exp_dec[$];
  int   exp_mix;

  bit m_active [VOICES];
  bit m_phase  [VOICES];
  int m_addr [VOICES], m_end [VOICES], m_byte [VOICES], m_step [VOICES], m_sample [VOICES];

  function automatic int clampi(int x, int lo, int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  // Yamaha-style ADPCM step/sample update used as the external decode datapath.
  function automatic int nxt_step(int code, int st);
    int f;
    case (code & 7)
      4: f = 77;
      5: f = 102;
      6: f = 128;
      7: f = 153;
      default: f = 57;
    endcase
    return clampi((st * f + 32) >>> 6, 127, 24576);
  endfunction

  function automatic int nxt_sample(int code, int st, int smp);
    int diff = ((2 * (code & 7) + 1) * st) >>> 3;
    return clampi(((code & 8) != 0) ? smp - diff : smp + diff, -32768, 32767);
  endfunction

  assign bus.io_dec_out_step = 17'(nxt_step(int'(bus.io_dec_data), int'(bus.io_dec_in_step)));
  assign bus.io_dec_out_sample = 17'(nxt_sample(int'(bus.io_dec_data), int'(bus.io_dec_in_step),
                                                 int'($signed(bus.io_dec_in_sample))));

  function automatic void model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_active[i] = 0; m_phase[i] = 0; m_addr[i] = 0; m_end[i] = 0;
      m_byte[i] = 0; m_step[i] = 127; m_sample[i] = 0;
    end
  endfunction

  function automatic void model_cmd(int voice, bit stop, int start, int last);
    if (voice >= VOICES) return;
    if (stop) begin
      m_active[voice] = 0; m_sample[voice] = 0;
    end else begin
      m_active[voice] = 1; m_addr[voice] = start; m_end[voice] = last;
      m_phase[voice] = 0; m_step[voice] = 127; m_sample[voice] = 0;
    end
  endfunction

  // One whole tick: decode one nibble per active voice, then sum the pass-start voices.
  function automatic void model_pass();
    bit mask [VOICES];
    int code, sum;
    exp_reads.delete();
    exp_dec.delete();
    for (int i = 0; i < VOICES; i++) mask[i] = m_active[i];
    for (int i = 0; i < VOICES; i++) begin
      if (m_active[i]) begin
        if (!m_phase[i]) begin
          m_byte[i] = int'(rom[m_addr[i] & 1023]);
          exp_reads.push_back(m_addr[i]);
        end
        code = m_phase[i] ? (m_byte[i] & 15) : (m_byte[i] >> 4);
        exp_dec.push_back('{code: 4'(code), step: 17'(m_step[i]), sample: 17'(m_sample[i])});
        m_sample[i] = nxt_sample(code, m_step[i], m_sample[i]);
        m_step[i]   = nxt_step(code, m_step[i]);
        if (m_phase[i]) begin
          if (m_addr[i] == m_end[i]) m_active[i] = 0;
          m_addr[i] = (m_addr[i] + 1) % (1 << AW);
        end
        m_phase[i] = !m_phase[i];
      end
    end
    sum = 0;
    for (int i = 0; i < VOICES; i++) if (mask[i]) sum += m_sample[i];
    exp_mix = clampi(sum, -32768, 32767);
  endfunction

  function automatic bit reads_ok();
    if (act_reads.size() != exp_reads.size()) return 0;
    foreach (act_reads[i]) if (act_reads[i] != exp_reads[i]) return 0;
    return 1;
  endfunction

  function automatic bit decs_ok();
    if (act_dec.size() != exp_dec.size()) return 0;
    foreach (act_dec[i]) if (act_dec[i] !== exp_dec[i]) return 0;
    return 1;
  endfunction

  // ROM arbiter with rom_lat cycles of latency, plus a log of every decode the DUT presents.
  initial begin
    int cnt = 0;
    bus.io_rom_valid = 1'b0;
    bus.io_rom_data  = '0;
    forever begin
      @(negedge clock);
      if (!bus.io_rom_rd) begin
        bus.io_rom_valid = 1'b0; cnt = 0;
      end else if (!bus.io_rom_valid) begin
        if (cnt >= rom_lat - 1) begin
          bus.io_rom_valid = 1'b1;
          bus.io_rom_data  = rom[bus.io_rom_addr[9:0]];
          act_reads.push_back(int'(bus.io_rom_addr));
        end else cnt++;
      end
      if (bus.io_dec_in_step != '0)
        act_dec.push_back('{code: bus.io_dec_data, step: bus.io_dec_in_step, sample: bus.io_dec_in_sample});
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic send_cmd(int voice, bit stop, int start, int last);
    int i;
    bus.io_cmd_valid = 1'b1;
    bus.io_cmd_voice = 3'(voice);
    bus.io_cmd_stop  = stop;
    bus.io_cmd_start = AW'(start);
    bus.io_cmd_end   = AW'(last);
    for (i = 0; i < 500 && !bus.io_cmd_ready; i++) @(negedge clock);
    if (!bus.io_cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: ready never rose, required ready=1");
    end
    @(negedge clock);
    bus.io_cmd_valid = 1'b0;
    model_cmd(voice, stop, start, last);
  endtask

  task automatic run_tick(output logic [15:0] aud, output bit ok);
    for (int i = 0; i < 500 && bus.io_busy; i++) @(negedge clock);
    act_reads.delete();
    act_dec.delete();
    bus.io_tick = 1'b1;
    @(negedge clock);
    bus.io_tick = 1'b0;
    ok = 0;
    aud = '0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.io_audio_valid) begin ok = 1; aud = bus.io_audio; break; end
      @(negedge clock);
    end
    model_pass();
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (bus.io_rom_rd !== 1'b0) begin errors++; $display("FAIL reset_rom_rd: got %b want 0", bus.io_rom_rd); end
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    checks++; if (bus.io_audio !== 16'h0) begin errors++; $display("FAIL reset_audio: got %h want 0", bus.io_audio); end
    checks++; if (bus.io_audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.io_audio_valid); end
    checks++; if (bus.io_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.io_overrun); end
    checks++; if (bus.io_cmd_ready !== 1'b1 || bus.io_busy !== 1'b0) begin errors++;
      $display("FAIL reset_idle: ready=%b busy=%b want 1/0", bus.io_cmd_ready, bus.io_busy); end
    checks++; if ({bus.io_dec_data, bus.io_dec_in_step, bus.io_dec_in_sample} !== '0) begin errors++;
      $display("FAIL reset_dec_idle: got %h/%h/%h want 0", bus.io_dec_data, bus.io_dec_in_step, bus.io_dec_in_sample); end
  endtask

  task automatic test_single_voice();
    logic [15:0] aud; bit ok;
    do_reset();
    rom[10'h100] = 8'h07;
    rom_lat = 2;
    send_cmd(0, 0, 'h100, 'h100);
    run_tick(aud, ok);
    checks++; if (!ok || aud !== 16'd15) begin errors++; $display("FAIL single_tick1_audio: got %0d ok=%0b want 15", aud, ok); end
    checks++; if (act_reads.size() != 1 || act_reads[0] != 'h100) begin errors++;
      $display("FAIL single_tick1_read: got %0d reads want one at 0x100", act_reads.size()); end
    checks++; if (act_dec.size() != 1 || act_dec[0].step !== 17'd127) begin errors++;
      $display("FAIL single_tick1_step: got %0d decodes want one with step 127", act_dec.size()); end
    run_tick(aud, ok);
    checks++; if (!ok || aud !== 16'd253) begin errors++; $display("FAIL single_tick2_audio: got %0d ok=%0b want 253", aud, ok); end
    checks++; if (act_reads.size() != 0 || !decs_ok()) begin errors++;
      $display("FAIL single_tick2_decode: reads=%0d decodes=%0d want 0/%0d", act_reads.size(), act_dec.size(), exp_dec.size()); end
    run_tick(aud, ok);
    checks++; if (!ok || aud !== 16'd0) begin errors++; $display("FAIL single_tick3_audio: got %0d ok=%0b want 0", aud, ok); end
  endtask

  task automatic test_saturation();
    logic [15:0] aud; bit ok;
    do_reset();
    rom_lat = 1;
    for (int v = 0; v < VOICES; v++) send_cmd(v, 0, 'h200 + v * 'h10, 'h2ff);
    for (int t = 0; t < 24; t++) begin
      run_tick(aud, ok);
      checks++; if (!ok || aud !== 16'(exp_mix) || aud[15]) begin errors++;
        $display("FAIL saturate_tick%0d: got %0d want %0d", t, $signed(aud), exp_mix); end
    end
    checks++; if (aud !== 16'h7fff) begin errors++; $display("FAIL saturate_final: got %h want 7fff", aud); end
    checks++; if (!reads_ok()) begin errors++; $display("FAIL saturate_reads: got %0d want %0d", act_reads.size(), exp_reads.size()); end
  endtask

  task automatic test_stop();
    logic [15:0] aud; bit ok;
    do_reset();
    rom_lat = 2;
    send_cmd(1, 0, 'h040, 'h048);
    send_cmd(3, 0, 'h050, 'h058);
    run_tick(aud, ok);
    checks++; if (!ok || aud !== 16'(exp_mix)) begin errors++; $display("FAIL stop_pre_audio: got %0d want %0d", $signed(aud), exp_mix); end
    send_cmd(1, 1, 0, 0);
    run_tick(aud, ok);
    checks++; if (!ok || aud !== 16'(exp_mix)) begin errors++; $display("FAIL stop_post_audio: got %0d want %0d", $signed(aud), exp_mix); end
    checks++; if (act_reads.size() != 0) begin errors++; $display("FAIL stop_no_read: got %0d reads want 0", act_reads.size()); end
    checks++; if (!decs_ok()) begin errors++; $display("FAIL stop_decodes: got %0d want %0d", act_dec.size(), exp_dec.size()); end
  endtask

  task automatic test_cmd_tick_same_cycle();
    logic [15:0] aud = '0; bit ok = 0;
    do_reset();
    rom_lat = 3;
    act_reads.delete();
    act_dec.delete();
    bus.io_cmd_valid = 1'b1; bus.io_cmd_voice = 3'd0; bus.io_cmd_stop = 1'b0;
    bus.io_cmd_start = AW'('h060); bus.io_cmd_end = AW'('h061);
    bus.io_tick = 1'b1;
    @(negedge clock);
    bus.io_cmd_valid = 1'b0; bus.io_tick = 1'b0;
    model_cmd(0, 0, 'h060, 'h061);
    model_pass();
    for (int i = 0; i < 500; i++) begin
      if (bus.io_audio_valid) begin ok = 1; aud = bus.io_audio; break; end
      @(negedge clock);
    end
    checks++; if (!ok || aud !== 16'(exp_mix)) begin errors++; $display("FAIL same_cycle_audio: got %0d want %0d", $signed(aud), exp_mix); end
    checks++; if (act_reads.size() != 1 || act_reads[0] != 'h060) begin errors++;
      $display("FAIL same_cycle_read: got %0d reads want one at 0x060", act_reads.size()); end
  endtask

  task automatic test_hold_and_overrun();
    logic [15:0] aud = '0; bit ok; int n_valid = 0; bit pend = 0, accepted = 0; int mix_first;
    do_reset();
    rom_lat = 2;
    send_cmd(0, 0, 'h010, 'h013);
    send_cmd(1, 0, 'h020, 'h025);
    act_reads.delete();
    act_dec.delete();
    model_pass();
    mix_first = exp_mix;
    bus.io_tick = 1'b1;
    @(negedge clock);
    checks++; if (bus.io_cmd_ready !== 1'b0 || bus.io_busy !== 1'b1) begin errors++;
      $display("FAIL hold_ready_low: ready=%b busy=%b want 0/1", bus.io_cmd_ready, bus.io_busy); end
    bus.io_cmd_valid = 1'b1; bus.io_cmd_voice = 3'd2; bus.io_cmd_stop = 1'b0;
    bus.io_cmd_start = AW'('h030); bus.io_cmd_end = AW'('h034);
    @(negedge clock);
    bus.io_tick = 1'b0;
    checks++; if (bus.io_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", bus.io_overrun); end
    for (int i = 0; i < 300; i++) begin
      if (pend) begin bus.io_cmd_valid = 1'b0; pend = 0; accepted = 1; end
      if (bus.io_audio_valid) begin n_valid++; aud = bus.io_audio; end
      if (bus.io_cmd_valid && bus.io_cmd_ready) pend = 1;
      @(negedge clock);
    end
    checks++; if (n_valid != 1) begin errors++; $display("FAIL overrun_valid_count: got %0d want 1", n_valid); end
    checks++; if (aud !== 16'(mix_first) || !reads_ok()) begin errors++;
      $display("FAIL hold_pass_audio: got %0d want %0d", $signed(aud), mix_first); end
    checks++; if (!accepted) begin errors++; $display("FAIL hold_cmd_accept: got 0 want 1"); end
    model_cmd(2, 0, 'h030, 'h034);
    run_tick(aud, ok);
    checks++; if (!ok || aud !== 16'(exp_mix) || !reads_ok()) begin errors++;
      $display("FAIL hold_after_audio: got %0d want %0d reads %0d/%0d", $signed(aud), exp_mix, act_reads.size(), exp_reads.size()); end
    checks++; if (bus.io_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", bus.io_overrun); end
  endtask

  task automatic test_random();
    logic [15:0] aud; bit ok; int r, s;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        s = $urandom_range(0, 'h1f0);
        send_cmd($urandom_range(0, 7), 0, s, s + $urandom_range(0, 4));
      end else if (r == 3) begin
        send_cmd($urandom_range(0, 7), 1, 0, 0);
      end else begin
        rom_lat = $urandom_range(1, 4);
        run_tick(aud, ok);
        checks++; if (!ok || aud !== 16'(exp_mix)) begin errors++; $display("FAIL rand_audio_%0d: got %0d want %0d", it, $signed(aud), exp_mix); end
        checks++; if (!reads_ok()) begin errors++; $display("FAIL rand_reads_%0d: got %0d want %0d", it, act_reads.size(), exp_reads.size()); end
        checks++; if (!decs_ok()) begin errors++; $display("FAIL rand_decodes_%0d: got %0d want %0d", it, act_dec.size(), exp_dec.size()); end
      end
    end
  endtask

  task automatic test_reset_during_fetch();
    logic [15:0] aud; bit ok;
    do_reset();
    rom[10'h070] = 8'h35;
    rom_lat = 1;
    send_cmd(0, 0, 'h070, 'h072);
    run_tick(aud, ok);
    send_cmd(1, 0, 'h080, 'h082);
    rom_lat = 20;
    bus.io_tick = 1'b1;
    @(negedge clock);
    bus.io_tick = 1'b0;
    for (int i = 0; i < 50 && !bus.io_rom_rd; i++) @(negedge clock);
    checks++; if (bus.io_rom_rd !== 1'b1) begin errors++; $display("FAIL rst_fetch_reached: got %b want 1", bus.io_rom_rd); end
    reset = 1'b0;
    #1;
    checks++; if (bus.io_rom_rd !== 1'b0 || bus.io_busy !== 1'b0) begin errors++;
      $display("FAIL rst_fetch_drop: rd=%b busy=%b want 0/0", bus.io_rom_rd, bus.io_busy); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
    rom_lat = 2;
    @(negedge clock);
    checks++; if (bus.io_audio !== 16'h0 || bus.io_overrun !== 1'b0) begin errors++;
      $display("FAIL rst_fetch_outputs: audio=%h overrun=%b want 0/0", bus.io_audio, bus.io_overrun); end
    run_tick(aud, ok);
    checks++; if (!ok || aud !== 16'h0 || act_reads.size() != 0) begin errors++;
      $display("FAIL rst_fetch_inactive: audio=%0d reads=%0d want 0/0", $signed(aud), act_reads.size()); end
  endtask

  initial begin
    bus.io_cmd_valid = 1'b0;
    bus.io_cmd_voice = '0;
    bus.io_cmd_stop  = 1'b0;
    bus.io_cmd_start = '0;
    bus.io_cmd_end   = '0;
    bus.io_tick      = 1'b0;
`ifdef ADPCM_SCHED_VOLUME_EN
    bus.io_cmd_vol   = '0;
`endif
    for (int i = 0; i < 1024; i++) rom[i] = (i >= 'h200) ? 8'h77 : 8'($urandom);
    model_reset();
    test_reset();
    test_single_voice();
    test_saturation();
    test_stop();
    test_cmd_tick_same_cycle();
    test_hold_and_overrun();
    test_random();
    test_reset_during_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
